// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encodings,
// vector addresses and the owner tag used to route read returns.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t BOOT_RD     = 2'd0;
  localparam state_t BOOT_WAIT   = 2'd1;
  localparam state_t RUN         = 2'd2;
  localparam state_t INT_RD_WAIT = 2'd3;

  localparam logic [7:0] RST_VEC_ADDR = 8'h00;
  localparam logic [7:0] INT_VEC_ADDR = 8'h01;

  // Who owns the memory port in a given cycle; a registered copy tags the read return.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DAT  = 2'd2,
    OWN_VEC  = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-facing and memory-facing signals of the port arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              int_req;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic              fetch_stall;
  logic              dat_req;
  logic              dat_we;
  logic [ADDR_W-1:0] dat_addr;
  logic [DATA_W-1:0] dat_wdata;
  logic              dat_gnt;
  logic              dat_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_vec;
  logic              int_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  int_req, if_req, if_addr, dat_req, dat_we, dat_addr, dat_wdata, mem_rdata,
    output if_gnt, if_rvalid, fetch_stall, dat_gnt, dat_rvalid, rdata,
           pc_load, pc_vec, int_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output int_req, if_req, if_addr, dat_req, dat_we, dat_addr, dat_wdata, mem_rdata,
    input  if_gnt, if_rvalid, fetch_stall, dat_gnt, dat_rvalid, rdata,
           pc_load, pc_vec, int_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while fetch waits; sat forces
// the next fetch through.
module arb_starve_cnt #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory between fetch, data and vector reads;
// runs the reset-vector boot read and sequences the interrupt-vector read.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  state_t            state, state_nxt;
  logic              int_pend;
  logic              int_win;
  owner_e            gnt_owner;
  owner_e            rd_owner;
  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] addr_mux;
  logic              starve_sat;
  logic              pc_load_q;
  logic              int_ack_q;
  logic [ADDR_W-1:0] pc_vec_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    gnt_owner = OWN_NONE;
    int_win   = 1'b0;
    state_nxt = state;
    vec_addr  = ADDR_W'(RST_VEC_ADDR);
    if (rst) begin
      case (state)
        BOOT_RD: begin
          gnt_owner = OWN_VEC;
          state_nxt = BOOT_WAIT;
        end
        BOOT_WAIT: state_nxt = RUN;
        RUN: begin
          if (starve_sat && bus.if_req) begin
            gnt_owner = OWN_IF;
          end else if (bus.dat_req) begin
            gnt_owner = OWN_DAT;
          end else if (int_pend) begin
            gnt_owner = OWN_VEC;
            int_win   = 1'b1;
            vec_addr  = ADDR_W'(INT_VEC_ADDR);
            state_nxt = INT_RD_WAIT;
          end else if (bus.if_req) begin
            gnt_owner = OWN_IF;
          end
        end
        INT_RD_WAIT: begin
          // The PC is being redirected, so only the data stage may use the port.
          if (bus.dat_req) gnt_owner = OWN_DAT;
          state_nxt = RUN;
        end
        default: state_nxt = BOOT_RD;
      endcase
    end
  end

  always_comb begin
    case (gnt_owner)
      OWN_IF:  addr_mux = bus.if_addr;
      OWN_DAT: addr_mux = bus.dat_addr;
      OWN_VEC: addr_mux = vec_addr;
      default: addr_mux = '0;
    endcase
  end

  assign bus.if_gnt      = (gnt_owner == OWN_IF);
  assign bus.dat_gnt     = (gnt_owner == OWN_DAT);
  assign bus.fetch_stall = bus.if_req && !bus.if_gnt;
  assign bus.mem_en      = (gnt_owner != OWN_NONE);
  assign bus.mem_we      = bus.dat_gnt && bus.dat_we;
  assign bus.mem_addr    = addr_mux;
  assign bus.mem_wdata   = bus.dat_gnt ? bus.dat_wdata : DATA_W'(0);
  assign bus.rdata       = bus.mem_rdata;

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.dat_gnt && bus.if_req),
    .clr (bus.if_gnt || !bus.if_req),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT_RD;
      int_pend  <= 1'b0;
      rd_owner  <= OWN_NONE;
      pc_load_q <= 1'b0;
      int_ack_q <= 1'b0;
      pc_vec_q  <= '0;
    end else begin
      state     <= state_nxt;
      // A new request in the same cycle as service keeps the interrupt pending.
      int_pend  <= bus.int_req || (int_pend && !int_win);
      rd_owner  <= (gnt_owner == OWN_IF)                    ? OWN_IF  :
                   (gnt_owner == OWN_DAT && !bus.dat_we)    ? OWN_DAT : OWN_NONE;
      pc_load_q <= (state == BOOT_WAIT) || (state == INT_RD_WAIT);
      int_ack_q <= (state == INT_RD_WAIT);
      if ((state == BOOT_WAIT) || (state == INT_RD_WAIT)) begin
        pc_vec_q <= ADDR_W'(bus.mem_rdata);
      end
    end
  end

  assign bus.if_rvalid  = (rd_owner == OWN_IF);
  assign bus.dat_rvalid = (rd_owner == OWN_DAT);
  assign bus.pc_load    = pc_load_q;
  assign bus.int_ack    = int_ack_q;
  assign bus.pc_vec     = pc_vec_q;

endmodule
